// File: rtl/estimator_pcpi_ctrl.sv
// PCPI front-end: decodes custom-0x27 instructions and sequences the estimator datapath.
// Define PCPI_PERF_CNT_EN to add the CALC latency counter reported by RDSTAT.
module estimator_pcpi_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic [31:0] dp_sdata,
    output logic        dp_push,
    output logic        dp_clr,
    output logic        dp_start,
    input  logic        dp_done,
    input  logic [31:0] dp_result,
    output logic [5:0]  pcpi_insn_decoded
);

    // state   | meaning
    // IDLE    | no instruction in flight
    // EXEC    | datapath strobe for the claimed instruction
    // WAIT_DP | CALC waiting for dp_done or timeout
    // DONE    | ready pulse; valid ignored so nothing re-executes

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_WAIT_DP = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_LOADS  = 2'd0,
        K_CLR    = 2'd1,
        K_CALC   = 2'd2,
        K_RDSTAT = 2'd3
    } kind_t;

    localparam logic [6:0]           OPC_CUSTOM   = 7'h27;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    kind_t                r_kind;
    kind_t                w_funct;
    logic                 w_match;
    logic                 w_busy;
    logic                 w_wait;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_clr;
    logic                 w_start;
    logic                 w_hit_done;
    logic                 w_hit_timeout;
    logic                 w_wait_tc;
    logic [31:0]          r_sdata;
    logic [31:0]          r_rd;
    logic                 r_wr;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] r_load_cnt;
    logic [CNT_WIDTH-1:0] r_wait_cnt;
    logic [15:0]          w_lat16;
    logic [31:0]          w_stat_word;
    logic                 w_unused_bits;

    // Gating with resetn keeps pcpi_wait low while reset is held, even if the core keeps valid up.
    assign w_match = resetn & pcpi_valid
                   & (pcpi_insn[6:0] == OPC_CUSTOM)
                   & (pcpi_insn[31:25] == 7'd0)
                   & ~pcpi_insn[14];
    assign w_funct       = kind_t'(pcpi_insn[13:12]);
    assign w_wait_tc     = (r_wait_cnt == '0);
    assign w_busy        = (r_state != S_IDLE);
    assign w_unused_bits = ^{pcpi_rs2, pcpi_insn[24:15], pcpi_insn[11:7]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait        = 1'b0;
        w_ready       = 1'b0;
        w_push        = 1'b0;
        w_clr         = 1'b0;
        w_start       = 1'b0;
        w_hit_done    = 1'b0;
        w_hit_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wait = w_match;
                if (w_match) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_wait  = w_match;
                w_push  = (r_kind == K_LOADS);
                w_clr   = (r_kind == K_CLR);
                w_start = (r_kind == K_CALC);
                w_state_nxt = (r_kind == K_CALC) ? S_WAIT_DP : S_DONE;
            end
            S_WAIT_DP: begin
                w_wait = w_match;
                // A flushed instruction abandons the calculation; the result beats a coincident timeout.
                if (!pcpi_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (dp_done) begin
                    w_hit_done  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_wait_tc) begin
                    w_hit_timeout = 1'b1;
                    w_state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_stat_word = {r_err, 7'd0, r_load_cnt[7:0], w_lat16};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_kind     <= K_LOADS;
            r_sdata    <= '0;
            r_rd       <= '0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            r_load_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_match) begin
                r_kind <= w_funct;
                if (w_funct == K_LOADS) begin
                    r_sdata <= pcpi_rs1;
                end
            end
            if (w_push) begin
                r_wr <= 1'b0;
                if (!(&r_load_cnt)) begin
                    r_load_cnt <= r_load_cnt + CNT_ONE;
                end
            end
            if (w_clr) begin
                r_wr       <= 1'b0;
                r_err      <= 1'b0;
                r_load_cnt <= '0;
            end
            if (w_start) begin
                r_load_cnt <= '0;
                r_wait_cnt <= TIMEOUT_LOAD;
            end
            if ((r_state == S_EXEC) && (r_kind == K_RDSTAT)) begin
                r_rd <= w_stat_word;
                r_wr <= 1'b1;
            end
            if ((r_state == S_WAIT_DP) && !w_wait_tc) begin
                r_wait_cnt <= r_wait_cnt - CNT_ONE;
            end
            if (w_hit_done) begin
                r_rd <= dp_result;
                r_wr <= 1'b1;
            end
            if (w_hit_timeout) begin
                r_rd  <= 32'hDEAD_BEEF;
                r_wr  <= 1'b1;
                r_err <= 1'b1;
            end
        end
    end

`ifdef PCPI_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_lat_cnt;

    // Counts WAIT_DP cycles, so a dp_done N cycles after dp_start reads back as N.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lat_cnt <= '0;
        end else if (w_start) begin
            r_lat_cnt <= '0;
        end else if ((r_state == S_WAIT_DP) && !(&r_lat_cnt)) begin
            r_lat_cnt <= r_lat_cnt + CNT_ONE;
        end
    end

    assign w_lat16 = r_lat_cnt[15:0];
`else
    assign w_lat16 = 16'd0;
`endif

    assign pcpi_wait  = w_wait;
    assign pcpi_ready = w_ready;
    assign pcpi_wr    = w_ready & r_wr;
    assign pcpi_rd    = r_rd;
    assign dp_sdata   = r_sdata;
    assign dp_push    = w_push;
    assign dp_clr     = w_clr;
    assign dp_start   = w_start;

    assign pcpi_insn_decoded = {r_err,
                                w_busy,
                                w_busy & (r_kind == K_RDSTAT),
                                w_busy & (r_kind == K_CALC),
                                w_busy & (r_kind == K_CLR),
                                w_busy & (r_kind == K_LOADS)};

endmodule

// File: tb/tb_estimator_pcpi_ctrl.sv
// Self-checking bench for estimator_pcpi_ctrl: directed vector table, random transactions
// against a transaction-level model, and hand-written flush/reset/illegal sequences.
module tb_estimator_pcpi_ctrl;

    localparam int TIMEOUT = 64;
`ifdef PCPI_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic [31:0] dp_sdata;
    logic        dp_push;
    logic        dp_clr;
    logic        dp_start;
    logic        dp_done;
    logic [31:0] dp_result;
    logic [5:0]  pcpi_insn_decoded;

    estimator_pcpi_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(16)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .pcpi_valid        (pcpi_valid),
        .pcpi_insn         (pcpi_insn),
        .pcpi_rs1          (pcpi_rs1),
        .pcpi_rs2          (pcpi_rs2),
        .pcpi_wr           (pcpi_wr),
        .pcpi_rd           (pcpi_rd),
        .pcpi_wait         (pcpi_wait),
        .pcpi_ready        (pcpi_ready),
        .dp_sdata          (dp_sdata),
        .dp_push           (dp_push),
        .dp_clr            (dp_clr),
        .dp_start          (dp_start),
        .dp_done           (dp_done),
        .dp_result         (dp_result),
        .pcpi_insn_decoded (pcpi_insn_decoded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model state
    int          m_load;
    bit          m_err;
    int          m_lat;
    logic [31:0] m_rd;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        int          d;
        logic [31:0] res;
        logic [31:0] exp_rd;
        logic        exp_wr;
        int          exp_rdy;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lat(input int v);
        return PERF ? 16'(v) : 16'h0;
    endfunction

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd3, 5'd2, f3, 5'd1, 7'h27};
    endfunction

    // d = cycles from dp_start to dp_done; outside 1..TIMEOUT the datapath never answers in time.
    task automatic model_step(input logic [2:0] f3, input logic [31:0] rs1, input int d,
                              input logic [31:0] res, output logic [31:0] e_rd,
                              output logic e_wr, output int e_rdy);
        e_rdy = 2;
        e_wr  = 1'b0;
        case (f3)
            3'd0: m_load = (m_load >= 65535) ? 65535 : m_load + 1;
            3'd1: begin m_load = 0; m_err = 1'b0; end
            3'd2: begin
                m_load = 0;
                e_wr   = 1'b1;
                if (d >= 1 && d <= TIMEOUT) begin
                    m_rd = res; m_lat = d; e_rdy = 2 + d;
                end else begin
                    m_rd = 32'hDEAD_BEEF; m_err = 1'b1; m_lat = TIMEOUT; e_rdy = 2 + TIMEOUT;
                end
            end
            default: begin
                e_wr = 1'b1;
                m_rd = {m_err, 7'd0, 8'(m_load), lat(m_lat)};
            end
        endcase
        if (rs1 == 32'h0) e_rd = m_rd; else e_rd = m_rd;
    endtask

    task automatic run_insn(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] rs1,
                            input int d, input logic [31:0] res,
                            output int rdy_c, output logic [31:0] rd_o, output logic wr_o,
                            output int n_push, output int n_clr, output int n_start,
                            output logic [31:0] sd_o, output logic [5:0] dec_o,
                            output int n_wait_bad);
        int start_c;
        rdy_c = -1; rd_o = '0; wr_o = 1'b0; sd_o = '0; dec_o = '0;
        n_push = 0; n_clr = 0; n_start = 0; n_wait_bad = 0; start_c = -1;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(f7, f3);
        pcpi_rs1   = rs1;
        #1;
        if (pcpi_wait !== 1'b1) n_wait_bad++;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            dp_done = 1'b0;
            if (c == 1) dec_o = pcpi_insn_decoded;
            if (dp_push) begin n_push++; sd_o = dp_sdata; end
            if (dp_clr) n_clr++;
            if (dp_start) begin n_start++; start_c = c; end
            if (pcpi_ready) begin
                rdy_c = c; rd_o = pcpi_rd; wr_o = pcpi_wr;
                if (pcpi_wait !== 1'b0) n_wait_bad++;
                break;
            end
            if (pcpi_wait !== 1'b1) n_wait_bad++;
            if (start_c >= 0 && d >= 0 && c == start_c + d) begin
                dp_done = 1'b1; dp_result = res;
            end
        end
        pcpi_valid = 1'b0;
        dp_done    = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                          input int d, input logic [31:0] res, input logic [31:0] exp_rd,
                          input logic exp_wr, input int exp_rdy, input logic err_pre);
        int rdy_c, n_push, n_clr, n_start, n_wb;
        logic [31:0] rd_o, sd_o;
        logic wr_o;
        logic [5:0] dec_o;
        run_insn(7'd0, f3, rs1, d, res, rdy_c, rd_o, wr_o, n_push, n_clr, n_start, sd_o, dec_o, n_wb);
        chk({tag, "_ready_cycle"}, rdy_c, exp_rdy);
        chk({tag, "_rd"}, rd_o, exp_rd);
        chk({tag, "_wr"}, {31'd0, wr_o}, {31'd0, exp_wr});
        chk({tag, "_strobes"}, n_push * 100 + n_clr * 10 + n_start,
            (f3 == 3'd0 ? 100 : 0) + (f3 == 3'd1 ? 10 : 0) + (f3 == 3'd2 ? 1 : 0));
        if (f3 == 3'd0) chk({tag, "_sdata"}, sd_o, rs1);
        chk({tag, "_decoded"}, dec_o,
            {err_pre, 1'b1, f3 == 3'd3, f3 == 3'd2, f3 == 3'd1, f3 == 3'd0});
        chk({tag, "_wait"}, n_wb, 0);
    endtask

    task automatic model_txn(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                             input int d, input logic [31:0] res);
        logic [31:0] e_rd;
        logic e_wr;
        int e_rdy;
        logic pre;
        pre = m_err;
        model_step(f3, rs1, d, res, e_rd, e_wr, e_rdy);
        do_txn(tag, f3, rs1, d, res, e_rd, e_wr, e_rdy, pre);
    endtask

    task automatic illegal(input string tag, input logic [6:0] f7, input logic [2:0] f3);
        int bad;
        bad = 0;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(f7, f3);
        repeat (20) begin
            @(negedge clk);
            if (pcpi_wait || pcpi_ready || pcpi_wr || dp_push || dp_clr || dp_start
                || pcpi_insn_decoded[4]) bad++;
        end
        pcpi_valid = 1'b0;
        chk(tag, bad, 0);
    endtask

    task automatic start_calc(input string tag);
        int found;
        found = 0;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'd0, 3'd2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dp_start) begin found = 1; break; end
        end
        chk({tag, "_start_seen"}, found, 1);
    endtask

    initial begin
        logic [31:0] e_rd;
        logic e_wr;
        int e_rdy, cnt;
        logic pre;

        resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0;
        pcpi_rs2 = 32'h5A5A_1234; dp_done = 1'b0; dp_result = '0;
        m_load = 0; m_err = 1'b0; m_lat = 0; m_rd = '0;

        tbl[0]  = '{3'd0, 32'hA5A5_0F0F, 0,  32'h0,         32'h0,                      1'b0, 2};
        tbl[1]  = '{3'd2, 32'h0,         4,  32'h0001_2345, 32'h0001_2345,              1'b1, 6};
        tbl[2]  = '{3'd3, 32'h0,         0,  32'h0,         {16'h0000, lat(4)},         1'b1, 2};
        tbl[3]  = '{3'd2, 32'h0,         -1, 32'h0,         32'hDEAD_BEEF,              1'b1, 66};
        tbl[4]  = '{3'd3, 32'h0,         0,  32'h0,         {16'h8000, lat(64)},        1'b1, 2};
        tbl[5]  = '{3'd1, 32'h0,         0,  32'h0,         {16'h8000, lat(64)},        1'b0, 2};
        tbl[6]  = '{3'd3, 32'h0,         0,  32'h0,         {16'h0000, lat(64)},        1'b1, 2};
        tbl[7]  = '{3'd0, 32'h1111_1111, 0,  32'h0,         {16'h0000, lat(64)},        1'b0, 2};
        tbl[8]  = '{3'd0, 32'h2222_2222, 0,  32'h0,         {16'h0000, lat(64)},        1'b0, 2};
        tbl[9]  = '{3'd0, 32'h3333_3333, 0,  32'h0,         {16'h0000, lat(64)},        1'b0, 2};
        tbl[10] = '{3'd3, 32'h0,         0,  32'h0,         {16'h0003, lat(64)},        1'b1, 2};
        tbl[11] = '{3'd2, 32'h0,         64, 32'h1234_5678, 32'h1234_5678,              1'b1, 66};
        tbl[12] = '{3'd3, 32'h0,         0,  32'h0,         {16'h0000, lat(64)},        1'b1, 2};
        tbl[13] = '{3'd2, 32'h0,         1,  32'hCAFE_0001, 32'hCAFE_0001,              1'b1, 3};
        tbl[14] = '{3'd3, 32'h0,         0,  32'h0,         {16'h0000, lat(1)},         1'b1, 2};
        tbl[15] = '{3'd2, 32'h0,         0,  32'h0BAD_0BAD, 32'hDEAD_BEEF,              1'b1, 66};
        tbl[16] = '{3'd3, 32'h0,         0,  32'h0,         {16'h8000, lat(64)},        1'b1, 2};
        tbl[17] = '{3'd1, 32'h0,         0,  32'h0,         {16'h8000, lat(64)},        1'b0, 2};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {26'd0, pcpi_wait, pcpi_ready, pcpi_wr, dp_push, dp_clr, dp_start}, 32'h0);
        chk("reset_decoded", pcpi_insn_decoded, 6'h0);
        chk("reset_rd", pcpi_rd, 32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            pre = m_err;
            model_step(tbl[i].f3, tbl[i].rs1, tbl[i].d, tbl[i].res, e_rd, e_wr, e_rdy);
            do_txn($sformatf("vec%0d", i), tbl[i].f3, tbl[i].rs1, tbl[i].d, tbl[i].res,
                   tbl[i].exp_rd, tbl[i].exp_wr, tbl[i].exp_rdy, pre);
        end

        for (int i = 0; i < 40; i++) begin
            int r, d;
            r = $urandom_range(0, 9);
            d = (r == 0) ? -1 : (r == 1) ? 64 : (r == 2) ? 65 : $urandom_range(0, 12);
            model_txn($sformatf("rnd%0d", i), 3'($urandom_range(0, 3)), $urandom, d, $urandom);
        end

        illegal("illegal_funct3_5", 7'd0, 3'd5);
        illegal("illegal_funct7_1", 7'h01, 3'd2);

        // Core flushes the CALC while it waits: no ready now or after a late dp_done.
        start_calc("vdrop");
        m_load = 0;
        repeat (2) @(negedge clk);
        pcpi_valid = 1'b0;
        @(negedge clk);
        chk("vdrop_idle", pcpi_insn_decoded[4], 1'b0);
        cnt = 0;
        dp_done = 1'b1; dp_result = 32'h7777_7777;
        @(negedge clk);
        dp_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (pcpi_ready || pcpi_wr) cnt++;
        end
        chk("vdrop_no_ready", cnt, 0);
        model_txn("post_vdrop_calc", 3'd2, 32'h0, 3, 32'h0ABC_DEF0);
        model_txn("post_vdrop_stat", 3'd3, 32'h0, 0, 32'h0);
        model_txn("post_vdrop_load", 3'd0, 32'hFEED_F00D, 0, 32'h0);

        // Asynchronous reset in the middle of WAIT_DP, valid still high.
        start_calc("rstwait");
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rstwait_ctrl", {20'd0, pcpi_wait, pcpi_ready, pcpi_wr, dp_push, dp_clr, dp_start,
                             pcpi_insn_decoded}, 32'h0);
        chk("rstwait_rd", pcpi_rd, 32'h0);
        chk("rstwait_sdata", dp_sdata, 32'h0);
        @(negedge clk);
        pcpi_valid = 1'b0;
        resetn = 1'b1;
        m_load = 0; m_err = 1'b0; m_lat = 0; m_rd = '0;
        cnt = 0;
        repeat (2) @(negedge clk);
        dp_done = 1'b1; dp_result = 32'h9999_9999;
        @(negedge clk);
        if (pcpi_ready) cnt++;
        dp_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (pcpi_ready || pcpi_wr) cnt++;
        end
        chk("rstwait_late_done", cnt, 0);
        model_txn("post_rst_stat", 3'd3, 32'h0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
